// File: rtl/uart_pkg.sv
// Shared UART transmit definitions: FSM state encoding and oversampling constants.
// Pure declarations; no timing or flow-control behaviour of its own.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam int         SAMPLES_PER_BIT = 16;
    localparam logic [3:0] SAMPLE_CNT_MAX  = 4'd15;

endpackage

// File: rtl/uart_tx_frame_ctrl_if.sv
// Parallel-write / serial-line bundle between a UART host and the transmit frame controller.
// master drives write, enable and oversampling tick; slave drives TxD, busy and done.
interface uart_tx_frame_ctrl_if #(
    parameter int DATA_BITS = 8
);
    logic                 Tx_EN;
    logic                 Tx_WR;
    logic [DATA_BITS-1:0] Tx_DATA;
    logic                 Tx_sample_ENABLE;
    logic                 TxD;
    logic                 Tx_BUSY;
    logic                 Tx_DONE;

    modport master (
        output Tx_EN, Tx_WR, Tx_DATA, Tx_sample_ENABLE,
        input  TxD, Tx_BUSY, Tx_DONE
    );

    modport slave (
        input  Tx_EN, Tx_WR, Tx_DATA, Tx_sample_ENABLE,
        output TxD, Tx_BUSY, Tx_DONE
    );
endinterface

// File: rtl/uart_tx_sample_counter.sv
// 4-bit oversampling tick counter; bit_done flags the 16th tick of a bit (same cycle as the tick).
// No backpressure: clear wins over counting, and the count holds while run or tick is low.
module uart_tx_sample_counter
    import uart_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    input  logic tick,
    output logic bit_done
);

    logic [3:0] cnt_q;

    // Wraps 15->0 naturally on the completing tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= 4'd0;
        end else if (clear) begin
            cnt_q <= 4'd0;
        end else if (run && tick) begin
            cnt_q <= cnt_q + 4'd1;
        end
    end

    assign bit_done = run && tick && (cnt_q == SAMPLE_CNT_MAX);

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART TX framer: start, LSB-first data, even parity if UART_PARITY_EN, stop; 16 ticks per bit.
// Outputs registered, TxD/Tx_BUSY valid one clk after accept; Tx_WR while busy or with Tx_EN low is dropped.
module uart_tx_frame_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    uart_tx_frame_ctrl_if.slave  tx
);

    localparam int                IDX_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DATA_BITS - 1);

    tx_state_t            state_q, state_n;
    logic [DATA_BITS-1:0] shift_q, shift_n;
    logic [IDX_W-1:0]     idx_q, idx_n;
    logic                 txd_q, txd_n;
    logic                 busy_q, busy_n;
    logic                 done_q, done_n;
    logic                 accept;
    logic                 bit_done;
`ifdef UART_PARITY_EN
    logic                 par_q, par_n;
`endif

    uart_tx_sample_counter u_sample_counter (
        .clk      (clk),
        .reset    (reset),
        .clear    (accept),
        .run      (state_q != IDLE),
        .tick     (tx.Tx_sample_ENABLE),
        .bit_done (bit_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef UART_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_n;
            shift_q <= shift_n;
            idx_q   <= idx_n;
            txd_q   <= txd_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
`ifdef UART_PARITY_EN
            par_q   <= par_n;
`endif
        end
    end

    always_comb begin
        state_n = state_q;
        shift_n = shift_q;
        idx_n   = idx_q;
        done_n  = 1'b0;
        accept  = 1'b0;
`ifdef UART_PARITY_EN
        par_n   = par_q;
`endif

        case (state_q)
            IDLE: begin
                if (tx.Tx_WR && tx.Tx_EN) begin
                    accept  = 1'b1;
                    state_n = START;
                    shift_n = tx.Tx_DATA;
                    idx_n   = '0;
`ifdef UART_PARITY_EN
                    // Latched up front because the shift register is consumed during DATA.
                    par_n   = ^tx.Tx_DATA;
`endif
                end
            end
            START: begin
                if (bit_done) state_n = DATA;
            end
            DATA: begin
                if (bit_done) begin
                    shift_n = {1'b0, shift_q[DATA_BITS-1:1]};
                    if (idx_q == LAST_IDX) begin
`ifdef UART_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end else begin
                        idx_n = idx_q + 1'b1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                if (bit_done) state_n = STOP;
            end
`endif
            STOP: begin
                if (bit_done) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        // Line level is decoded from the next state so TxD leaves a flop with no input path.
        case (state_n)
            START:   txd_n = 1'b0;
            DATA:    txd_n = shift_n[0];
`ifdef UART_PARITY_EN
            PARITY:  txd_n = par_n;
`endif
            default: txd_n = 1'b1;
        endcase

        busy_n = (state_n != IDLE);
    end

    assign tx.TxD     = txd_q;
    assign tx.Tx_BUSY = busy_q;
    assign tx.Tx_DONE = done_q;

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Self-checking bench for uart_tx_frame_ctrl: random tick spacing and data against a bit-list frame model.
// Honours UART_PARITY_EN the same way the design does.
module tb_uart_tx_frame_ctrl;

    localparam int DATA_BITS = 8;
    localparam int SPB       = uart_pkg::SAMPLES_PER_BIT;
`ifdef UART_PARITY_EN
    localparam int NBITS     = DATA_BITS + 3;
`else
    localparam int NBITS     = DATA_BITS + 2;
`endif
    localparam int FRAME_TICKS = NBITS * SPB;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    uart_tx_frame_ctrl_if #(.DATA_BITS(DATA_BITS)) tx_if ();

    uart_tx_frame_ctrl #(.DATA_BITS(DATA_BITS)) dut (
        .clk   (clk),
        .reset (reset),
        .tx    (tx_if.slave)
    );

    always #5 clk = ~clk;

    // Reference frame as an ordered list of line levels, one entry per bit period.
    function automatic logic [15:0] expected_frame(input logic [DATA_BITS-1:0] d);
        logic [15:0] f;
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < DATA_BITS; i++) f[1+i] = d[i];
`ifdef UART_PARITY_EN
        f[DATA_BITS+1] = ^d;
`endif
        f[NBITS-1] = 1'b1;
        return f;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Sends one frame and checks it tick by tick. Optionally injects a Tx_WR or drops Tx_EN at a given tick.
    task automatic run_frame(input logic [7:0] data, input int gap_lo, input int gap_hi,
                             input int wr_at, input logic [7:0] wr_data, input int en_drop_at,
                             input string name);
        logic [15:0] exp_f;
        logic [15:0] obs_f;
        int unstable = 0;
        int busy_err = 0;
        int done_cnt = 0;
        int done_at  = -1;
        int idx      = 0;
        exp_f = expected_frame(data);
        obs_f = '1;

        tx_if.Tx_WR            = 1'b1;
        tx_if.Tx_DATA          = data;
        tx_if.Tx_sample_ENABLE = 1'($urandom_range(0, 1));
        cycle();
        tx_if.Tx_WR            = 1'b0;
        tx_if.Tx_DATA          = 8'($urandom);
        tx_if.Tx_sample_ENABLE = 1'b0;
        tests++;
        if (tx_if.TxD !== 1'b0 || tx_if.Tx_BUSY !== 1'b1) begin
            fails++;
            $display("FAIL %s accept: TxD=%b Tx_BUSY=%b, expected TxD=0 Tx_BUSY=1",
                     name, tx_if.TxD, tx_if.Tx_BUSY);
        end

        for (int b = 0; b < NBITS; b++) begin
            for (int s = 0; s < SPB; s++) begin
                if (s == 0) obs_f[b] = tx_if.TxD;
                else if (tx_if.TxD !== obs_f[b]) unstable++;
                if (tx_if.Tx_BUSY !== 1'b1) busy_err++;
                tx_if.Tx_sample_ENABLE = 1'b1;
                if (idx == wr_at) begin
                    tx_if.Tx_WR   = 1'b1;
                    tx_if.Tx_DATA = wr_data;
                end
                if (idx == en_drop_at) tx_if.Tx_EN = 1'b0;
                cycle();
                idx++;
                tx_if.Tx_sample_ENABLE = 1'b0;
                tx_if.Tx_WR            = 1'b0;
                if (tx_if.Tx_DONE === 1'b1) begin
                    done_cnt++;
                    done_at = idx;
                end
                if (idx < FRAME_TICKS) begin
                    repeat ($urandom_range(gap_lo, gap_hi)) begin
                        cycle();
                        if (tx_if.Tx_DONE === 1'b1) begin
                            done_cnt++;
                            done_at = -2;
                        end
                    end
                end
            end
        end

        tests++;
        if (obs_f[NBITS-1:0] !== exp_f[NBITS-1:0]) begin
            fails++;
            $display("FAIL %s bits: data=%h line=%b expected=%b (LSB first)",
                     name, data, obs_f[NBITS-1:0], exp_f[NBITS-1:0]);
        end
        tests++;
        if (unstable != 0 || busy_err != 0) begin
            fails++;
            $display("FAIL %s bit_hold: %0d unstable samples, %0d busy-low samples, expected 0 and 0",
                     name, unstable, busy_err);
        end
        tests++;
        if (done_cnt != 1 || done_at != FRAME_TICKS) begin
            fails++;
            $display("FAIL %s done: %0d pulses, last after tick %0d, expected 1 pulse after tick %0d",
                     name, done_cnt, done_at, FRAME_TICKS);
        end
        tests++;
        if (tx_if.Tx_BUSY !== 1'b0 || tx_if.TxD !== 1'b1) begin
            fails++;
            $display("FAIL %s end_idle: Tx_BUSY=%b TxD=%b, expected 0 and 1",
                     name, tx_if.Tx_BUSY, tx_if.TxD);
        end
    endtask

    task automatic idle_check(input int n, input string name);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            tx_if.Tx_sample_ENABLE = 1'($urandom_range(0, 1));
            cycle();
            if (tx_if.TxD !== 1'b1 || tx_if.Tx_BUSY !== 1'b0 || tx_if.Tx_DONE !== 1'b0) bad++;
        end
        tx_if.Tx_sample_ENABLE = 1'b0;
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL %s: %0d of %0d idle cycles not TxD=1 Tx_BUSY=0 Tx_DONE=0", name, bad, n);
        end
    endtask

    task automatic test_reset();
        reset                  = 1'b1;
        tx_if.Tx_EN            = 1'b1;
        tx_if.Tx_WR            = 1'b0;
        tx_if.Tx_DATA          = '0;
        tx_if.Tx_sample_ENABLE = 1'b0;
        repeat (3) cycle();
        tests++;
        if (tx_if.TxD !== 1'b1 || tx_if.Tx_BUSY !== 1'b0 || tx_if.Tx_DONE !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: TxD=%b Tx_BUSY=%b Tx_DONE=%b, expected 1 0 0",
                     tx_if.TxD, tx_if.Tx_BUSY, tx_if.Tx_DONE);
        end
        reset = 1'b0;
        cycle();

        // 0xA5 aborted 40 ticks in, while data bit 1 (a zero) is on the line.
        tx_if.Tx_WR   = 1'b1;
        tx_if.Tx_DATA = 8'hA5;
        cycle();
        tx_if.Tx_WR = 1'b0;
        repeat (40) begin
            tx_if.Tx_sample_ENABLE = 1'b1;
            cycle();
            tx_if.Tx_sample_ENABLE = 1'b0;
            cycle();
        end
        tests++;
        if (tx_if.TxD !== 1'b0 || tx_if.Tx_BUSY !== 1'b1) begin
            fails++;
            $display("FAIL reset_pre_abort: TxD=%b Tx_BUSY=%b, expected 0 and 1",
                     tx_if.TxD, tx_if.Tx_BUSY);
        end
        #2 reset = 1'b1;
        #1;
        tests++;
        if (tx_if.TxD !== 1'b1 || tx_if.Tx_BUSY !== 1'b0 || tx_if.Tx_DONE !== 1'b0) begin
            fails++;
            $display("FAIL reset_async: TxD=%b Tx_BUSY=%b Tx_DONE=%b, expected 1 0 0",
                     tx_if.TxD, tx_if.Tx_BUSY, tx_if.Tx_DONE);
        end
        cycle();
        reset = 1'b0;
        cycle();
        run_frame(8'h3C, 0, 2, -1, 8'h00, -1, "reset_fresh_3C");
    endtask

    task automatic test_basic();
        run_frame(8'h55, 3, 3, -1, 8'h00, -1, "basic_55");
        idle_check(8, "basic_idle");
    endtask

    task automatic test_parity();
        run_frame(8'h07, 0, 2, -1, 8'h00, -1, "parity_07");
        idle_check(3, "parity_gap");
        run_frame(8'h00, 0, 2, -1, 8'h00, -1, "parity_00");
        idle_check(3, "parity_idle");
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            run_frame(8'($urandom), 0, 2, -1, 8'h00, -1, "random");
            idle_check($urandom_range(1, 5), "random_idle");
        end
    endtask

    task automatic test_busy_reject();
        run_frame(8'h12, 0, 2, 40, 8'hFF, -1, "busy_reject_12");
        idle_check(60, "busy_no_second_frame");
    endtask

    task automatic test_back_to_back();
        run_frame(8'($urandom), 0, 1, -1, 8'h00, -1, "b2b_first");
        run_frame(8'h81, 0, 1, -1, 8'h00, -1, "b2b_81");
        run_frame(8'($urandom), 0, 1, FRAME_TICKS - 1, 8'h81, -1, "b2b_last_tick_wr");
        idle_check(20, "b2b_last_tick_ignored");
    endtask

    task automatic test_enable();
        tx_if.Tx_EN   = 1'b0;
        tx_if.Tx_WR   = 1'b1;
        tx_if.Tx_DATA = 8'($urandom);
        cycle();
        tx_if.Tx_WR = 1'b0;
        idle_check(20, "enable_gate_idle");
        tx_if.Tx_EN = 1'b1;
        run_frame(8'($urandom), 0, 2, -1, 8'h00, 50, "enable_drop_mid");
        tx_if.Tx_WR   = 1'b1;
        tx_if.Tx_DATA = 8'hFF;
        cycle();
        tx_if.Tx_WR = 1'b0;
        idle_check(20, "enable_low_after_frame");
        tx_if.Tx_EN = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_random();
        test_busy_reject();
        test_back_to_back();
        test_enable();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
